mem_ctrl: RTL

Memory controller sitting between the two L1 caches and main memory. It accepts one block-miss or write-back request at a time from each cache through valid/ready handshakes. It arbitrates round-robin between them and issues at most one request per cycle to the pipelined main memory. It routes each main-memory response back to the originating cache by its cache type, and tracks per-client latency with a watchdog.

---
 rtl/mem_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Memory controller: round-robin arbitration of I-cache and D-cache block requests onto a
// pipelined main memory, with response routing by cache type and per-client watchdogs.
package mem_ctrl_pkg;
   typedef logic [7:0]  main_mem_block_addr_t;
   typedef logic [63:0] block_data_t;
   typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
   typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_type_t;
endpackage

module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 icache_req_valid,
   output logic                 icache_req_ready,
   input  main_mem_block_addr_t icache_req_block_addr,
   output logic                 icache_resp_valid,
   output block_data_t          icache_resp_block_data,
   input  logic                 dcache_req_valid,
   output logic                 dcache_req_ready,
   input  req_type_t            dcache_req_type,
   input  main_mem_block_addr_t dcache_req_block_addr,
   input  block_data_t          dcache_req_block_data,
   output logic                 dcache_resp_valid,
   output block_data_t          dcache_resp_block_data,
   output logic                 mm_req_valid,
   output cache_type_t          mm_req_cache_type,
   output req_type_t            mm_req_type,
   output main_mem_block_addr_t mm_req_block_addr,
   output block_data_t          mm_req_block_data,
   input  logic                 mm_resp_valid,
   input  cache_type_t          mm_resp_cache_type,
   input  block_data_t          mm_resp_block_data,
   output logic                 err_timeout,
   output logic                 err_unexpected_resp
);

   localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESP_TIMEOUT);

   typedef enum logic [1:0] {StIdle, StPending, StWait} state_t;

   state_t               i_state_q, i_state_d, d_state_q, d_state_d;
   main_mem_block_addr_t i_addr_q, i_addr_d, d_addr_q, d_addr_d;
   req_type_t            d_type_q, d_type_d;
   block_data_t          d_data_q, d_data_d;
   cache_type_t          last_grant_q, last_grant_d;
   logic [CNT_W-1:0]     i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
   logic                 i_resp_valid_q, i_resp_valid_d, d_resp_valid_q, d_resp_valid_d;
   block_data_t          i_resp_data_q, i_resp_data_d, d_resp_data_q, d_resp_data_d;
   logic                 mm_valid_q, mm_valid_d;
   cache_type_t          mm_ct_q, mm_ct_d;
   req_type_t            mm_type_q, mm_type_d;
   main_mem_block_addr_t mm_addr_q, mm_addr_d;
   block_data_t          mm_data_q, mm_data_d;
   logic                 err_to_q, err_to_d, err_ur_q, err_ur_d;

   logic i_pend, d_pend, grant_i, grant_d, i_hit, d_hit;

   always_comb begin
      i_state_d      = i_state_q;
      d_state_d      = d_state_q;
      i_addr_d       = i_addr_q;
      d_addr_d       = d_addr_q;
      d_type_d       = d_type_q;
      d_data_d       = d_data_q;
      last_grant_d   = last_grant_q;
      i_cnt_d        = i_cnt_q;
      d_cnt_d        = d_cnt_q;
      i_resp_valid_d = 1'b0;
      d_resp_valid_d = 1'b0;
      i_resp_data_d  = i_resp_data_q;
      d_resp_data_d  = d_resp_data_q;
      mm_valid_d     = 1'b0;
      mm_ct_d        = ICACHE;
      mm_type_d      = READ;
      mm_addr_d      = '0;
      mm_data_d      = '0;
      err_to_d       = err_to_q;
      err_ur_d       = err_ur_q;

      i_pend  = (i_state_q == StPending);
      d_pend  = (d_state_q == StPending);
      // On a tie the client that did not win last time is granted.
      grant_i = i_pend && (!d_pend || last_grant_q == DCACHE);
      grant_d = d_pend && !grant_i;
      i_hit   = mm_resp_valid && (mm_resp_cache_type == ICACHE);
      d_hit   = mm_resp_valid && (mm_resp_cache_type == DCACHE);

      unique case (i_state_q)
         StIdle: if (icache_req_valid) begin
            i_addr_d  = icache_req_block_addr;
            i_state_d = StPending;
         end
         StPending: if (grant_i) begin
            mm_valid_d   = 1'b1;
            mm_ct_d      = ICACHE;
            mm_type_d    = READ;
            mm_addr_d    = i_addr_q;
            last_grant_d = ICACHE;
            i_cnt_d      = '0;
            i_state_d    = StWait;
         end
         StWait: if (i_hit) begin
            i_resp_valid_d = 1'b1;
            i_resp_data_d  = mm_resp_block_data;
            i_state_d      = StIdle;
         end else begin
            if (i_cnt_q != CNT_MAX) i_cnt_d = i_cnt_q + 1'b1;
            if (i_cnt_d == CNT_MAX) err_to_d = 1'b1;
         end
         default: i_state_d = StIdle;
      endcase

      unique case (d_state_q)
         StIdle: if (dcache_req_valid) begin
            d_type_d  = dcache_req_type;
            d_addr_d  = dcache_req_block_addr;
            d_data_d  = dcache_req_block_data;
            d_state_d = StPending;
         end
         StPending: if (grant_d) begin
            mm_valid_d   = 1'b1;
            mm_ct_d      = DCACHE;
            mm_type_d    = d_type_q;
            mm_addr_d    = d_addr_q;
            mm_data_d    = d_data_q;
            last_grant_d = DCACHE;
            d_cnt_d      = '0;
            d_state_d    = StWait;
         end
         StWait: if (d_hit) begin
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = mm_resp_block_data;
            d_state_d      = StIdle;
         end else begin
            if (d_cnt_q != CNT_MAX) d_cnt_d = d_cnt_q + 1'b1;
            if (d_cnt_d == CNT_MAX) err_to_d = 1'b1;
         end
         default: d_state_d = StIdle;
      endcase

      if ((i_hit && i_state_q != StWait) || (d_hit && d_state_q != StWait)) err_ur_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_state_q      <= StIdle;
         d_state_q      <= StIdle;
         i_addr_q       <= '0;
         d_addr_q       <= '0;
         d_type_q       <= READ;
         d_data_q       <= '0;
         last_grant_q   <= DCACHE;
         i_cnt_q        <= '0;
         d_cnt_q        <= '0;
         i_resp_valid_q <= 1'b0;
         d_resp_valid_q <= 1'b0;
         i_resp_data_q  <= '0;
         d_resp_data_q  <= '0;
         mm_valid_q     <= 1'b0;
         mm_ct_q        <= ICACHE;
         mm_type_q      <= READ;
         mm_addr_q      <= '0;
         mm_data_q      <= '0;
         err_to_q       <= 1'b0;
         err_ur_q       <= 1'b0;
      end else begin
         i_state_q      <= i_state_d;
         d_state_q      <= d_state_d;
         i_addr_q       <= i_addr_d;
         d_addr_q       <= d_addr_d;
         d_type_q       <= d_type_d;
         d_data_q       <= d_data_d;
         last_grant_q   <= last_grant_d;
         i_cnt_q        <= i_cnt_d;
         d_cnt_q        <= d_cnt_d;
         i_resp_valid_q <= i_resp_valid_d;
         d_resp_valid_q <= d_resp_valid_d;
         i_resp_data_q  <= i_resp_data_d;
         d_resp_data_q  <= d_resp_data_d;
         mm_valid_q     <= mm_valid_d;
         mm_ct_q        <= mm_ct_d;
         mm_type_q      <= mm_type_d;
         mm_addr_q      <= mm_addr_d;
         mm_data_q      <= mm_data_d;
         err_to_q       <= err_to_d;
         err_ur_q       <= err_ur_d;
      end
   end

   assign icache_req_ready       = (i_state_q == StIdle);
   assign dcache_req_ready       = (d_state_q == StIdle);
   assign icache_resp_valid      = i_resp_valid_q;
   assign icache_resp_block_data = i_resp_data_q;
   assign dcache_resp_valid      = d_resp_valid_q;
   assign dcache_resp_block_data = d_resp_data_q;
   assign mm_req_valid           = mm_valid_q;
   assign mm_req_cache_type      = mm_ct_q;
   assign mm_req_type            = mm_type_q;
   assign mm_req_block_addr      = mm_addr_q;
   assign mm_req_block_data      = mm_data_q;
   assign err_timeout            = err_to_q;
   assign err_unexpected_resp    = err_ur_q;

endmodule
